// File: rtl/pitch_glide_control.sv
`default_nettype none
// ============================================================================
// Module  : pitch_glide_control
// Brief   : Per-slot exponential portamento on the (voice,osc) pitch sweep.
//           Optional legato glide mode enabled by PITCH_GLIDE_LEGATO_EN.
// Rev     : 1.0  initial release
// ============================================================================
module pitch_glide_control #(
  parameter int VOICES   = 8,
  parameter int V_OSC    = 4,
  parameter int V_WIDTH  = 3,
  parameter int O_WIDTH  = 2,
  parameter int OE_WIDTH = 1,
  parameter int P_WIDTH  = 24
) (
  input  logic                                sCLK_XVXOSC,
  input  logic                                reset_n,
  input  logic [V_WIDTH+O_WIDTH+OE_WIDTH-1:0] xxxx,
  input  logic [P_WIDTH-1:0]                  target_pitch,
  input  logic                                target_valid,
  input  logic                                note_on,
  input  logic [V_WIDTH-1:0]                  note_voice,
  input  logic                                held_other,
  input  logic [7:0]                          synth_data_in,
  input  logic [6:0]                          adr,
  input  logic                                write,
  input  logic                                read,
  input  logic                                com_sel,
  output logic [7:0]                          glide_regdata_out,
  output logic [P_WIDTH-1:0]                  glided_pitch,
  output logic                                glided_valid,
  output logic [VOICES-1:0]                   voice_gliding
);

  localparam int c_NSLOT = VOICES * V_OSC;
  localparam int c_SW    = V_WIDTH + O_WIDTH;
  localparam int c_XW    = V_WIDTH + O_WIDTH + OE_WIDTH;
  localparam logic [6:0] c_ADR_MODE  = 7'h20;
  localparam logic [6:0] c_ADR_SHIFT = 7'h21;
  localparam logic [6:0] c_ADR_DIV   = 7'h22;
  localparam logic signed [P_WIDTH:0] c_STEP_ONE   = 1;
  localparam logic signed [P_WIDTH:0] c_STEP_MINUS = '1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GLIDE = 1'b1} glide_st_t;

  logic [1:0]                       r_mode;
  logic [3:0]                       r_shift;
  logic [7:0]                       r_div;
  logic [7:0]                       r_tick_cnt;
  logic [P_WIDTH-1:0]               r_cur [c_NSLOT];
  glide_st_t                        r_st  [c_NSLOT];
  logic [c_NSLOT-1:0]               r_cur_valid;
  logic [VOICES-1:0]                r_arm;
  logic [VOICES-1:0]                r_snap;
  logic [VOICES-1:0][V_OSC-1:0]     r_seen;

  logic [c_SW-1:0]                  w_slot;
  logic [V_WIDTH-1:0]               w_vx;
  logic [O_WIDTH-1:0]               w_ox;
  logic                             w_tick;
  logic                             w_snap_set;
  logic [V_OSC-1:0]                 w_seen_nxt;
  logic [P_WIDTH-1:0]               w_cur;
  logic [P_WIDTH-1:0]               w_sum;
  logic [P_WIDTH-1:0]               w_cur_nxt;
  logic signed [P_WIDTH:0]          w_diff;
  logic signed [P_WIDTH:0]          w_shr;
  logic signed [P_WIDTH:0]          w_step;
  glide_st_t                        w_st_mid;
  glide_st_t                        w_st_nxt;
  logic [VOICES-1:0]                w_vg_nxt;
  logic                             w_unused;

  assign w_slot     = xxxx[c_XW-1:OE_WIDTH];
  assign w_vx       = xxxx[c_XW-1:O_WIDTH+OE_WIDTH];
  assign w_ox       = xxxx[O_WIDTH+OE_WIDTH-1:OE_WIDTH];
  assign w_tick     = (r_tick_cnt == r_div);
  assign w_seen_nxt = r_seen[w_vx] | (V_OSC'(1) << w_ox);
  assign w_unused   = ^{xxxx[OE_WIDTH-1:0], w_step[P_WIDTH], held_other};

`ifdef PITCH_GLIDE_LEGATO_EN
  assign w_snap_set = (r_mode == 2'd0) || ((r_mode == 2'd2) && !held_other);
`else
  assign w_snap_set = (r_mode == 2'd0);
`endif

  // Step is d >>> shift, floored to +-1 so every glide terminates exactly on target.
  always_comb begin
    w_cur  = r_cur[w_slot];
    w_diff = $signed({1'b0, target_pitch}) - $signed({1'b0, w_cur});
    w_shr  = w_diff >>> r_shift;
    if (w_shr != '0)          w_step = w_shr;
    else if (w_diff[P_WIDTH]) w_step = c_STEP_MINUS;
    else if (w_diff != '0)    w_step = c_STEP_ONE;
    else                      w_step = '0;
    w_sum = w_cur + w_step[P_WIDTH-1:0];

    w_st_mid  = r_st[w_slot];
    w_st_nxt  = w_st_mid;
    w_cur_nxt = w_cur;
    if (!r_cur_valid[w_slot] || r_snap[w_vx] || (r_mode == 2'd0)) begin
      w_cur_nxt = target_pitch;
      w_st_nxt  = ST_IDLE;
    end else begin
      if ((w_st_mid == ST_IDLE) && r_arm[w_vx] && (w_cur != target_pitch))
        w_st_mid = ST_GLIDE;
      w_st_nxt = w_st_mid;
      if ((w_st_mid == ST_GLIDE) && w_tick) begin
        w_cur_nxt = w_sum;
        w_st_nxt  = (w_sum == target_pitch) ? ST_IDLE : ST_GLIDE;
      end
    end
  end

  always_comb begin
    w_vg_nxt = '0;
    for (int s = 0; s < c_NSLOT; s++) begin
      if (target_valid && (w_slot == c_SW'(s))) begin
        if (w_st_nxt == ST_GLIDE) w_vg_nxt[s / V_OSC] = 1'b1;
      end else if (r_st[s] == ST_GLIDE) begin
        w_vg_nxt[s / V_OSC] = 1'b1;
      end
    end
  end

  always_ff @(posedge sCLK_XVXOSC or negedge reset_n) begin
    if (!reset_n) begin
      r_mode            <= 2'd0;
      r_shift           <= 4'd4;
      r_div             <= 8'd0;
      glide_regdata_out <= 8'd0;
    end else begin
      if (com_sel && read) begin
        case (adr)
          c_ADR_MODE:  glide_regdata_out <= {6'd0, r_mode};
          c_ADR_SHIFT: glide_regdata_out <= {4'd0, r_shift};
          c_ADR_DIV:   glide_regdata_out <= r_div;
          default:     ;
        endcase
      end
      if (com_sel && write) begin
        case (adr)
          c_ADR_MODE:  r_mode  <= synth_data_in[1:0];
          c_ADR_SHIFT: r_shift <= synth_data_in[3:0];
          c_ADR_DIV:   r_div   <= synth_data_in;
          default:     ;
        endcase
      end
    end
  end

  // A note_on landing on the same cycle as a visit of its voice wins over that visit.
  always_ff @(posedge sCLK_XVXOSC or negedge reset_n) begin
    if (!reset_n) begin
      r_arm  <= '0;
      r_snap <= '0;
      r_seen <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (note_on && (note_voice == V_WIDTH'(v))) begin
          r_arm[v]  <= 1'b1;
          r_snap[v] <= w_snap_set;
          r_seen[v] <= '0;
        end else if (target_valid && (w_vx == V_WIDTH'(v))) begin
          if (&w_seen_nxt) begin
            r_arm[v]  <= 1'b0;
            r_snap[v] <= 1'b0;
            r_seen[v] <= '0;
          end else begin
            r_seen[v] <= w_seen_nxt;
          end
        end
      end
    end
  end

  always_ff @(posedge sCLK_XVXOSC or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < c_NSLOT; s++) begin
        r_cur[s] <= '0;
        r_st[s]  <= ST_IDLE;
      end
      r_cur_valid   <= '0;
      r_tick_cnt    <= 8'd0;
      glided_pitch  <= '0;
      glided_valid  <= 1'b0;
      voice_gliding <= '0;
    end else begin
      glided_valid  <= target_valid;
      voice_gliding <= w_vg_nxt;
      if (target_valid) begin
        r_tick_cnt          <= w_tick ? 8'd0 : r_tick_cnt + 8'd1;
        r_cur[w_slot]       <= w_cur_nxt;
        r_st[w_slot]        <= w_st_nxt;
        r_cur_valid[w_slot] <= 1'b1;
        glided_pitch        <= w_cur_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pitch_glide_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_pitch_glide_control
// Brief   : Directed + random stimulus against a behavioural glide model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pitch_glide_control;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic [5:0]  xxxx = '0;
  logic [23:0] target_pitch = '0;
  logic        target_valid = 1'b0;
  logic        note_on = 1'b0;
  logic [2:0]  note_voice = '0;
  logic        held_other = 1'b0;
  logic [7:0]  synth_data_in = '0;
  logic [6:0]  adr = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        com_sel = 1'b0;
  logic [7:0]  glide_regdata_out;
  logic [23:0] glided_pitch;
  logic        glided_valid;
  logic [7:0]  voice_gliding;

  int total = 0;
  int bad   = 0;

  pitch_glide_control dut (
    .sCLK_XVXOSC       (clk),
    .reset_n           (reset_n),
    .xxxx              (xxxx),
    .target_pitch      (target_pitch),
    .target_valid      (target_valid),
    .note_on           (note_on),
    .note_voice        (note_voice),
    .held_other        (held_other),
    .synth_data_in     (synth_data_in),
    .adr               (adr),
    .write             (write),
    .read              (read),
    .com_sel           (com_sel),
    .glide_regdata_out (glide_regdata_out),
    .glided_pitch      (glided_pitch),
    .glided_valid      (glided_valid),
    .voice_gliding     (voice_gliding)
  );

  // Reference model state: one entry per (voice,osc) slot, plain integers.
  longint   m_cur   [32];
  bit       m_valid [32];
  bit       m_gl    [32];
  bit       m_arm   [8];
  bit       m_snap  [8];
  bit       m_seen  [8][4];
  int       m_tick = 0, m_mode = 0, m_shift = 4, m_div = 0;
  longint   exp_pitch = 0;
  bit       exp_valid = 1'b0;
  bit [7:0] exp_vg = '0;
  int       exp_rd = 0;

  task automatic check(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 32; s++) begin
      m_cur[s] = 0; m_valid[s] = 0; m_gl[s] = 0;
    end
    for (int v = 0; v < 8; v++) begin
      m_arm[v] = 0; m_snap[v] = 0;
      for (int o = 0; o < 4; o++) m_seen[v][o] = 0;
    end
    m_tick = 0; m_mode = 0; m_shift = 4; m_div = 0;
    exp_pitch = 0; exp_valid = 0; exp_vg = '0; exp_rd = 0;
  endfunction

  function automatic void model_step();
    int v, o, s, nv;
    bit tick, snapset;
    longint t, d, q, step;
    nv = int'(note_voice);
`ifdef PITCH_GLIDE_LEGATO_EN
    snapset = (m_mode == 0) || (m_mode == 2 && !held_other);
`else
    snapset = (m_mode == 0);
`endif
    if (target_valid) begin
      tick   = (m_tick == m_div);
      m_tick = tick ? 0 : (m_tick + 1) % 256;
      v = int'(xxxx) / 8;
      o = (int'(xxxx) / 2) % 4;
      s = v * 4 + o;
      t = longint'(target_pitch);
      if (!m_valid[s] || m_snap[v] || m_mode == 0) begin
        m_cur[s] = t;
        m_gl[s]  = 0;
      end else begin
        if (!m_gl[s] && m_arm[v] && m_cur[s] != t) m_gl[s] = 1;
        if (m_gl[s] && tick) begin
          d = t - m_cur[s];
          q = longint'(1) << m_shift;
          step = (d >= 0) ? d / q : -((-d + q - 1) / q);
          if (step == 0) step = (d > 0) ? 1 : ((d < 0) ? -1 : 0);
          m_cur[s] = m_cur[s] + step;
          if (m_cur[s] == t) m_gl[s] = 0;
        end
      end
      m_valid[s] = 1;
      exp_pitch  = m_cur[s];
      exp_valid  = 1;
      if (!(note_on && nv == v)) begin
        m_seen[v][o] = 1;
        if (m_seen[v][0] && m_seen[v][1] && m_seen[v][2] && m_seen[v][3]) begin
          m_arm[v] = 0; m_snap[v] = 0;
          for (int k = 0; k < 4; k++) m_seen[v][k] = 0;
        end
      end
    end else begin
      exp_valid = 0;
    end
    if (note_on) begin
      m_arm[nv]  = 1;
      m_snap[nv] = snapset;
      for (int k = 0; k < 4; k++) m_seen[nv][k] = 0;
    end
    for (int vv = 0; vv < 8; vv++)
      exp_vg[vv] = m_gl[vv*4] || m_gl[vv*4+1] || m_gl[vv*4+2] || m_gl[vv*4+3];
    if (com_sel && read) begin
      if (adr == 7'h20) exp_rd = m_mode;
      else if (adr == 7'h21) exp_rd = m_shift;
      else if (adr == 7'h22) exp_rd = m_div;
    end
    if (com_sel && write) begin
      if (adr == 7'h20) m_mode = int'(synth_data_in[1:0]);
      else if (adr == 7'h21) m_shift = int'(synth_data_in[3:0]);
      else if (adr == 7'h22) m_div = int'(synth_data_in);
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    check("pitch", longint'(glided_pitch), exp_pitch);
    check("valid", longint'(glided_valid), longint'(exp_valid));
    check("gliding", longint'(voice_gliding), longint'(exp_vg));
    check("regdata", longint'(glide_regdata_out), longint'(exp_rd));
  end

  task automatic cyc(input bit v, input logic [5:0] x, input logic [23:0] t,
                     input bit no = 1'b0, input logic [2:0] nv = 3'd0, input bit ho = 1'b0);
    target_valid = v; xxxx = x; target_pitch = t;
    note_on = no; note_voice = nv; held_other = ho;
    com_sel = 1'b0; write = 1'b0; read = 1'b0;
    @(negedge clk);
  endtask

  task automatic regop(input bit wr, input logic [6:0] a, input logic [7:0] d);
    target_valid = 1'b0; note_on = 1'b0;
    com_sel = 1'b1; write = wr; read = !wr; adr = a; synth_data_in = d;
    @(negedge clk);
    com_sel = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          changes;
    logic [23:0] prev;
    logic [5:0]  sweep;
    logic [23:0] tg [32];
    int          slot;

    repeat (3) @(negedge clk);
    check("rst_pitch", longint'(glided_pitch), 0);
    check("rst_valid", longint'(glided_valid), 0);
    check("rst_gliding", longint'(voice_gliding), 0);
    reset_n = 1'b1;
    regop(1'b0, 7'h21, 8'd0);
    check("rd_shift_default", longint'(glide_regdata_out), 4);
    regop(1'b0, 7'h22, 8'd0);
    check("rd_div_default", longint'(glide_regdata_out), 0);

    // Sweep after reset: every slot snaps to its target.
    for (int x = 0; x < 64; x++) begin
      cyc(1'b1, 6'(x), 24'h100000);
      check("sweep_pitch", longint'(glided_pitch), 24'h100000);
    end
    check("sweep_gliding", longint'(voice_gliding), 0);

    // Exponential glide, shift 2, every visit ticks.
    regop(1'b1, 7'h20, 8'd1);
    regop(1'b1, 7'h21, 8'd2);
    regop(1'b0, 7'h21, 8'd0);
    check("rd_shift_written", longint'(glide_regdata_out), 2);
    cyc(1'b0, 6'd0, 24'h0, 1'b1, 3'd0);
    cyc(1'b1, 6'd0, 24'h100100);
    check("glide_step1", longint'(glided_pitch), 24'h100040);
    check("model_step1", exp_pitch, 24'h100040);
    cyc(1'b1, 6'd0, 24'h100100);
    check("glide_step2", longint'(glided_pitch), 24'h100070);
    cyc(1'b1, 6'd0, 24'h100100);
    check("glide_step3", longint'(glided_pitch), 24'h100094);
    check("glide_active", longint'(voice_gliding[0]), 1);
    for (int i = 0; i < 100 && glided_pitch != 24'h100100; i++) cyc(1'b1, 6'd0, 24'h100100);
    check("glide_final", longint'(glided_pitch), 24'h100100);
    check("glide_done", longint'(voice_gliding[0]), 0);

    // Mode 0 jumps.
    regop(1'b1, 7'h20, 8'd0);
    cyc(1'b0, 6'd0, 24'h0, 1'b1, 3'd0);
    cyc(1'b1, 6'd0, 24'h100200);
    check("mode0_jump", longint'(glided_pitch), 24'h100200);
    check("mode0_gliding", longint'(voice_gliding[0]), 0);

    // Tick divider 3: two updates across eight consecutive visits.
    regop(1'b1, 7'h20, 8'd1);
    regop(1'b1, 7'h22, 8'd3);
    cyc(1'b0, 6'd0, 24'h0, 1'b1, 3'd1);
    prev = 24'h100000;
    changes = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 6'd8, 24'h200000);
      if (glided_pitch != prev) changes++;
      prev = glided_pitch;
    end
    check("div3_updates", longint'(changes), 2);
    regop(1'b1, 7'h22, 8'd0);

    // Retarget mid-glide reverses from the current value.
    cyc(1'b0, 6'd0, 24'h0, 1'b1, 3'd2);
    repeat (3) cyc(1'b1, 6'd16, 24'h100100);
    check("retgt_before", longint'(glided_pitch), 24'h100094);
    cyc(1'b1, 6'd16, 24'h0FFF00);
    check("retgt_reverse", longint'(glided_pitch), 24'h10002F);
    check("model_reverse", exp_pitch, 24'h10002F);
    for (int i = 0; i < 100 && glided_pitch != 24'h0FFF00; i++) cyc(1'b1, 6'd16, 24'h0FFF00);
    check("retgt_final", longint'(glided_pitch), 24'h0FFF00);

    // Minimum step of one at shift 15.
    regop(1'b1, 7'h21, 8'd15);
    regop(1'b1, 7'h20, 8'd0);
    cyc(1'b1, 6'd24, 24'h000010);
    regop(1'b1, 7'h20, 8'd1);
    cyc(1'b0, 6'd0, 24'h0, 1'b1, 3'd3);
    cyc(1'b1, 6'd24, 24'h000013);
    check("minstep_1", longint'(glided_pitch), 24'h000011);
    cyc(1'b1, 6'd24, 24'h000013);
    check("minstep_2", longint'(glided_pitch), 24'h000012);
    cyc(1'b1, 6'd24, 24'h000013);
    check("minstep_3", longint'(glided_pitch), 24'h000013);
    check("minstep_done", longint'(voice_gliding[3]), 0);
    cyc(1'b1, 6'd24, 24'h00000E);
    check("minstep_down", longint'(glided_pitch), 24'h000012);

    // Mode 2: snap without held key only in legato builds.
    regop(1'b1, 7'h21, 8'd2);
    regop(1'b1, 7'h20, 8'd2);
    cyc(1'b0, 6'd0, 24'h0, 1'b1, 3'd4, 1'b0);
    cyc(1'b1, 6'd32, 24'h100100);
`ifdef PITCH_GLIDE_LEGATO_EN
    check("mode2_unheld", longint'(glided_pitch), 24'h100100);
`else
    check("mode2_unheld", longint'(glided_pitch), 24'h100040);
`endif
    cyc(1'b0, 6'd0, 24'h0, 1'b1, 3'd5, 1'b1);
    cyc(1'b1, 6'd40, 24'h100100);
    check("mode2_held", longint'(glided_pitch), 24'h100040);
    check("mode2_gliding", longint'(voice_gliding[5]), 1);

    // Reset mid-glide, then first visit snaps.
    #2 reset_n = 1'b0;
    #1;
    check("midrst_pitch", longint'(glided_pitch), 0);
    check("midrst_gliding", longint'(voice_gliding), 0);
    @(negedge clk);
    reset_n = 1'b1;
    regop(1'b1, 7'h20, 8'd1);
    cyc(1'b1, 6'd40, 24'h123456);
    check("post_rst_snap", longint'(glided_pitch), 24'h123456);

    // Randomised traffic against the model.
    sweep = '0;
    for (int s = 0; s < 32; s++) tg[s] = 24'($urandom);
    for (int i = 0; i < 3000; i++) begin
      target_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) sweep = 6'($urandom);
      else if (target_valid) sweep = sweep + 6'd1;
      xxxx = sweep;
      slot = int'(sweep) / 2;
      if ($urandom_range(0, 19) == 0) tg[slot] = 24'($urandom);
      else if ($urandom_range(0, 9) == 0) tg[slot] = tg[slot] + 24'($urandom_range(0, 2047)) - 24'd1024;
      target_pitch  = tg[slot];
      note_on       = ($urandom_range(0, 15) == 0);
      note_voice    = 3'($urandom);
      held_other    = 1'($urandom);
      com_sel       = ($urandom_range(0, 9) == 0);
      write         = 1'($urandom);
      read          = 1'($urandom);
      adr           = 7'(7'h1F + 7'($urandom_range(0, 4)));
      synth_data_in = (adr == 7'h22) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      @(negedge clk);
    end
    cyc(1'b0, 6'd0, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
